// File: rtl/seq_alu.sv
// Multi-cycle ALU: registered single-cycle ops plus iterative MUL and DIV/REM under a start/done handshake.
// Define SEQ_ALU_DIV_EN to build the divider; without it DIV/REM complete in one cycle with result 0.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [3:0]       ALU_Operation_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic [WIDTH-1:0] pc_plus_4_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             Zero_o,
    output logic [WIDTH-1:0] ALU_Result_o
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W   = SHAMT_W + 1;

    localparam logic [3:0] OP_ADD = 4'b0000, OP_LUI = 4'b0001, OP_ORI = 4'b0010, OP_SLLI = 4'b0011;
    localparam logic [3:0] OP_SRLI = 4'b0100, OP_SUB = 4'b0101, OP_MUL = 4'b0110, OP_AND = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1000, OP_BEQ = 4'b1001, OP_BNE = 4'b1010, OP_BLT = 4'b1011;
    localparam logic [3:0] OP_BGE = 4'b1100, OP_JAL = 4'b1101, OP_DIV = 4'b1110, OP_REM = 4'b1111;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             neg_q, neg_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sc_result;
    logic [WIDTH-1:0] fix_res;
    logic [SHAMT_W-1:0] shamt;
`ifdef SEQ_ALU_DIV_EN
    logic             div_zero_q, div_zero_d;
    logic [WIDTH:0]   rem_sh;
`endif

    function automatic logic is_iter(input logic [3:0] op);
`ifdef SEQ_ALU_DIV_EN
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
`else
        return (op == OP_MUL);
`endif
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign shamt = B_i[SHAMT_W-1:0];

    // Branch ops return 0 when taken so Zero_o doubles as the branch-taken flag.
    always_comb begin
        sc_result = '0;
        case (ALU_Operation_i)
            OP_ADD:  sc_result = A_i + B_i;
            OP_LUI:  sc_result = B_i << 12;
            OP_ORI:  sc_result = A_i | B_i;
            OP_SLLI: sc_result = A_i << shamt;
            OP_SRLI: sc_result = A_i >> shamt;
            OP_SUB:  sc_result = A_i - B_i;
            OP_AND:  sc_result = A_i & B_i;
            OP_XOR:  sc_result = A_i ^ B_i;
            OP_BEQ:  sc_result = (A_i == B_i) ? '0 : WIDTH'(1);
            OP_BNE:  sc_result = (A_i != B_i) ? '0 : WIDTH'(1);
            OP_BLT:  sc_result = ($signed(A_i) <  $signed(B_i)) ? '0 : WIDTH'(1);
            OP_BGE:  sc_result = ($signed(A_i) >= $signed(B_i)) ? '0 : WIDTH'(1);
            OP_JAL:  sc_result = pc_plus_4_i;
            default: sc_result = '0;
        endcase
    end

    // NOTE: every signal assigned in this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_d    = neg_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        fix_res  = '0;
`ifdef SEQ_ALU_DIV_EN
        div_zero_d = div_zero_q;
        rem_sh     = {acc_q, a_q[WIDTH-1]};
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (is_iter(ALU_Operation_i)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        op_d    = ALU_Operation_i;
                        acc_d   = '0;
                        a_d     = abs_val(A_i);
                        b_d     = abs_val(B_i);
                        neg_d   = (ALU_Operation_i == OP_REM) ? A_i[WIDTH-1]
                                                              : A_i[WIDTH-1] ^ B_i[WIDTH-1];
`ifdef SEQ_ALU_DIV_EN
                        div_zero_d = (B_i == '0);
`endif
                    end else begin
                        result_d = sc_result;
                        zero_d   = (ALU_Operation_i == OP_JAL) || (sc_result == '0);
                        done_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                if (op_q == OP_MUL) begin
                    acc_d = b_q[0] ? acc_q + a_q : acc_q;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                end
`ifdef SEQ_ALU_DIV_EN
                else begin
                    // a_q shifts dividend bits out of its top while quotient bits enter at the bottom.
                    if (rem_sh >= {1'b0, b_q}) begin
                        acc_d = rem_sh[WIDTH-1:0] - b_q;
                        a_d   = {a_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = rem_sh[WIDTH-1:0];
                        a_d   = {a_q[WIDTH-2:0], 1'b0};
                    end
                end
`endif
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                fix_res = neg_q ? -acc_q : acc_q;
`ifdef SEQ_ALU_DIV_EN
                // Most-negative / -1 needs no special path: the magnitude quotient wraps back to A.
                if (op_q == OP_DIV) fix_res = div_zero_q ? '1 : (neg_q ? -a_q : a_q);
`endif
                result_d = fix_res;
                zero_d   = (fix_res == '0);
                done_d   = 1'b1;
                cnt_d    = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: datapath registers are reset too, so an aborted operation leaves no stale state behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
`ifdef SEQ_ALU_DIV_EN
            div_zero_q <= div_zero_d;
`endif
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;
    assign Zero_o       = zero_q;
    assign ALU_Result_o = result_q;
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle ALU, the next-generation execute unit for the RISC-V core. It keeps the existing single-cycle operation set and op encoding, registers its outputs, and adds iterative RV32M-style multiply, divide and remainder under a start/done handshake. The unit sits between the register-file/immediate muxes and the writeback mux. The control unit stalls the PC while `busy_o` is high.

## Interface
- `WIDTH`, 32, datapath width; legal range 16..64.
- `SHAMT_W`, `$clog2(WIDTH)`, local parameter; width of the shift-amount field, taken from the low bits of B.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  launches an operation; sampled only while idle.
- `ALU_Operation_i`  in  4  operation code; sampled together with `start_i`.
- `A_i`  in  WIDTH  operand A, signed; sampled with `start_i`.
- `B_i`  in  WIDTH  operand B, signed; sampled with `start_i`.
- `pc_plus_4_i`  in  WIDTH  return address for JAL.
- `busy_o`  out  1  high while an iterative operation is running.
- `done_o`  out  1  one-cycle pulse when the result becomes valid.
- `Zero_o`  out  1  branch-taken / zero flag for the held result.
- `ALU_Result_o`  out  WIDTH  result; held until the next `done_o`.

## Operation
- Op codes:
  - ADD 0000, LUI 0001, ORI 0010, SLLI 0011, SRLI 0100, SUB 0101, AND 0111, XOR 1000.
  - BEQ 1001, BNE 1010, BLT 1011, BGE 1100, JAL 1101.
  - MUL 0110, DIV 1110, REM 1111.
- Single-cycle op semantics:
  - LUI = B<<12.
  - Shifts use `B_i[SHAMT_W-1:0]`. SRLI is a logical shift.
  - Branch ops give result 0 when the condition holds and 1 otherwise. Compares are signed.
  - JAL gives `pc_plus_4_i`.
  - Unused codes give 0.
- MUL: low WIDTH bits of A*B, using shift-add with one bit per cycle on operand magnitudes, then sign correction.
- DIV/REM: signed restoring division, one quotient bit per cycle on magnitudes, then sign fix. Quotient rounds toward zero; the remainder takes the dividend's sign.
- DIV/REM special cases:
  - B=0: DIV gives all ones; REM gives A.
  - A = most-negative and B = -1: DIV gives A; REM gives 0.
  - Both cases finish with the same latency as a normal DIV/REM.
- `Zero_o`: 1 if the latched op is JAL or the result is 0, else 0. It is updated only together with `ALU_Result_o`.
- FSM states:
  - IDLE: when `start_i` is high and the op is single-cycle, stay in IDLE. When `start_i` is high and the op is MUL, DIV or REM, go to RUN.
  - RUN: stay for WIDTH iterations, counted by a counter of width SHAMT_W+1, then go to FIX.
  - FIX: apply sign correction and special cases, write outputs, go to IDLE.
- `start_i` while busy is ignored. Operands may change freely after the start edge.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `Zero_o`=0, `ALU_Result_o`=0; FSM in IDLE; counter 0.
- Single-cycle op: start is sampled at edge E. After E, `ALU_Result_o`, `Zero_o` and `done_o`=1 are valid. `busy_o` stays 0.
- Iterative op, start sampled at edge E:
  - `busy_o`=1 from E through edge E+WIDTH.
  - FIX happens at E+WIDTH+1. Result and `done_o`=1 are valid after that edge, and `busy_o` returns to 0 at the same edge.
  - Latency is WIDTH+1 cycles; 33 for WIDTH=32.
- Back-to-back: a new start may be sampled in the same cycle that `done_o` is high.
- `done_o` returns to 0 on the next edge unless a new single-cycle op completes.
- Reset during RUN aborts the operation immediately. All outputs take their reset values and no `done_o` is issued.

## Configuration
- `SEQ_ALU_DIV_EN` defined: DIV and REM are implemented as above.
- `SEQ_ALU_DIV_EN` undefined:
  - The divider datapath is removed.
  - Codes 1110 and 1111 complete as single-cycle ops with result 0 and `Zero_o`=1. `busy_o` never rises for them.
  - MUL is unaffected.

## Test plan
- WIDTH=32, ADD with A=5, B=-5 -> one cycle: result 0x00000000, `Zero_o`=1, `done_o` pulse, `busy_o`=0.
- MUL with A=7, B=-3 -> `busy_o` high for 33 cycles, then result 0xFFFFFFEB, `Zero_o`=0, single `done_o` pulse.
- DIV A=-7, B=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF. DIV A=5, B=0 -> 0xFFFFFFFF. REM A=5, B=0 -> 5.
- DIV with A=0x80000000, B=-1 -> 0x80000000; REM with the same operands -> 0. A second `start_i` pulsed mid-RUN is ignored and the result is unchanged.
- Reset asserted at cycle 10 of a MUL -> all outputs 0 immediately, no `done_o`. A following BEQ with A=B=3 -> result 0, `Zero_o`=1 after one cycle.
- With `SEQ_ALU_DIV_EN` undefined: DIV with A=9, B=3 -> one cycle, result 0, `Zero_o`=1, `busy_o`=0.
